prover_round_ctrl: RTL and testbench

PROVER_ROUND_CTRL -- requirements
Module: prover_round_ctrl

---
 rtl/prover_round_ctrl.sv | 158 +++++++++++++++
 tb/tb_prover_round_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prover_round_ctrl.sv
// Sumcheck prover round sequencer: two phases of NPOINTS rounds, each round being
// compute -> emit round polynomial -> accept verifier challenge, with per-gate enables.
module prover_round_ctrl #(
    parameter int NPOINTS = 5,
    parameter int NGATES  = 1 << (NPOINTS - 1)
) (
    input  logic                         clk,
    input  logic                         rstb,
    input  logic                         start,
    output logic                         comp_go,
    input  logic                         comp_done,
    output logic                         coef_valid,
    input  logic                         coef_ready,
    input  logic                         tau_valid,
    output logic                         tau_ready,
    output logic                         phase,
    output logic [$clog2(NPOINTS+1)-1:0] round,
    output logic [NPOINTS-1:0]           rnd_mask,
    output logic [NGATES-1:0]            p1_mul_en,
    output logic [NGATES-1:0]            p2_mul_en,
    output logic [NGATES-1:0]            add_en,
    output logic                         busy,
    output logic                         done
);
    localparam int RW = $clog2(NPOINTS + 1);
    localparam int GW = (NGATES > 1) ? $clog2(NGATES) : 1;
    localparam logic [RW-1:0] LAST_ROUND = RW'(NPOINTS - 1);

    function automatic int lsb_of(input int g);
        int r;
        r = NPOINTS - 1;
        for (int b = NPOINTS - 1; b >= 0; b--) begin
            if (((g >> b) & 1) != 0) r = b;
        end
        return r;
    endfunction

    // Gate indices are reversed over their own width, so rev(8) = 1 for 16 gates.
    function automatic int rev_of(input int g);
        int r;
        r = 0;
        for (int b = 0; b < GW; b++) begin
            if (((g >> b) & 1) != 0) r = r | (1 << (GW - 1 - b));
        end
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, COMPUTE, EMIT, RAND} state_t;

    state_t          state_reg, state_next;
    logic            phase_next;
    logic [RW-1:0]   round_next;
    logic            go_next, done_next;
    logic            active_next;
    logic [NPOINTS-1:0] low_mask, mask_next;
    logic [NGATES-1:0]  p1_next, p2_next, add_next;

    always_comb begin
        state_next = state_reg;
        phase_next = phase;
        round_next = round;
        go_next    = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = COMPUTE;
                    phase_next = 1'b0;
                    round_next = '0;
                    go_next    = 1'b1;
                end
            end
            COMPUTE: begin
                if (comp_done) state_next = EMIT;
            end
            EMIT: begin
                if (coef_ready) state_next = RAND;
            end
            RAND: begin
                if (tau_valid) begin
                    if (round != LAST_ROUND) begin
                        state_next = COMPUTE;
                        round_next = round + 1'b1;
                        go_next    = 1'b1;
                    end else if (!phase) begin
                        state_next = COMPUTE;
                        phase_next = 1'b1;
                        round_next = '0;
                        go_next    = 1'b1;
                    end else begin
                        state_next = IDLE;
                        phase_next = 1'b0;
                        round_next = '0;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign active_next = (state_next != IDLE);

    genvar gi;
    for (gi = 0; gi < NPOINTS; gi++) begin : g_mask
        assign low_mask[gi] = (round_next > RW'(gi));
    end

    always_comb begin
        mask_next = '0;
        if (active_next) mask_next = phase_next ? ~low_mask : low_mask;
    end

    // Enables are derived from next-cycle round/phase so they land with them.
    for (gi = 0; gi < NGATES; gi++) begin : g_gate
        localparam int THR = NPOINTS - 2 - lsb_of(gi);
        localparam logic [NPOINTS-1:0] REV = NPOINTS'(rev_of(gi));
        logic thr_met;
        if (THR <= 0) begin : g_always
            assign thr_met = 1'b1;
        end else begin : g_cmp
            assign thr_met = (round_next >= RW'(THR));
        end
        assign p1_next[gi]  = active_next && !phase_next && thr_met;
        assign p2_next[gi]  = active_next && phase_next && ((REV & low_mask) == '0);
        assign add_next[gi] = active_next && phase_next && (((REV >> 1) & low_mask) == '0);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg  <= IDLE;
            phase      <= 1'b0;
            round      <= '0;
            comp_go    <= 1'b0;
            done       <= 1'b0;
            coef_valid <= 1'b0;
            tau_ready  <= 1'b0;
            busy       <= 1'b0;
            rnd_mask   <= '0;
            p1_mul_en  <= '0;
            p2_mul_en  <= '0;
            add_en     <= '0;
        end else begin
            state_reg  <= state_next;
            phase      <= phase_next;
            round      <= round_next;
            comp_go    <= go_next;
            done       <= done_next;
            coef_valid <= (state_next == EMIT);
            tau_ready  <= (state_next == RAND);
            busy       <= active_next;
            rnd_mask   <= mask_next;
            p1_mul_en  <= p1_next;
            p2_mul_en  <= p2_next;
            add_en     <= add_next;
        end
    end
endmodule

// File: tb/tb_prover_round_ctrl.sv
// Directed bench for prover_round_ctrl: per-round expectations are queued at start
// and checked against the DUT each time comp_go pulses.
module tb_prover_round_ctrl;
    localparam int NPOINTS = 5;
    localparam int NGATES  = 16;

    logic clk = 1'b0;
    logic rstb = 1'b0;
    logic start = 1'b0, comp_done = 1'b0, coef_ready = 1'b0, tau_valid = 1'b0;
    logic comp_go, coef_valid, tau_ready, phase, busy, done;
    logic [2:0]         round;
    logic [NPOINTS-1:0] rnd_mask;
    logic [NGATES-1:0]  p1_mul_en, p2_mul_en, add_en;

    prover_round_ctrl #(.NPOINTS(NPOINTS), .NGATES(NGATES)) dut (
        .clk(clk), .rstb(rstb), .start(start), .comp_go(comp_go), .comp_done(comp_done),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .tau_valid(tau_valid),
        .tau_ready(tau_ready), .phase(phase), .round(round), .rnd_mask(rnd_mask),
        .p1_mul_en(p1_mul_en), .p2_mul_en(p2_mul_en), .add_en(add_en),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct { int ph; int rd; } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0, done_cnt = 0, go_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NPOINTS-1:0] m_mask(input int ph, input int rd);
        int low;
        low = (1 << rd) - 1;
        return ph != 0 ? NPOINTS'(~low) : NPOINTS'(low);
    endfunction

    function automatic logic [NGATES-1:0] m_p1(input int ph, input int rd);
        logic [NGATES-1:0] v;
        v = '0;
        for (int g = 0; g < NGATES; g++) begin
            int l;
            bit found;
            l = NPOINTS - 1;
            found = 0;
            for (int b = 0; b < NPOINTS; b++)
                if (!found && ((g >> b) % 2) == 1) begin l = b; found = 1; end
            v[g] = (ph == 0) && (rd >= NPOINTS - 2 - l);
        end
        return v;
    endfunction

    function automatic int m_rev(input int g);
        int r;
        r = 0;
        for (int b = 0; b < 4; b++) r = r * 2 + ((g >> b) % 2);
        return r;
    endfunction

    function automatic logic [NGATES-1:0] m_p2(input int ph, input int rd, input bit is_add);
        logic [NGATES-1:0] v;
        v = '0;
        for (int g = 0; g < NGATES; g++) begin
            int r;
            r = is_add ? m_rev(g) / 2 : m_rev(g);
            v[g] = (ph == 1) && ((r % (1 << rd)) == 0);
        end
        return v;
    endfunction

    task automatic cycle();
        exp_t e;
        @(posedge clk); #1;
        chk("valid_ready_exclusive", coef_valid & tau_ready, 0);
        if (done) done_cnt++;
        if (comp_go) begin
            go_cnt++;
            chk("go_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("phase", phase, e.ph);
                chk("round", round, e.rd);
                chk("busy_in_run", busy, 1);
                chk("rnd_mask", rnd_mask, m_mask(e.ph, e.rd));
                chk("p1_mul_en", p1_mul_en, m_p1(e.ph, e.rd));
                chk("p2_mul_en", p2_mul_en, m_p2(e.ph, e.rd, 0));
                chk("add_en", add_en, m_p2(e.ph, e.rd, 1));
                if (e.ph == 0 && e.rd == 2) begin
                    chk("p1r2_mask", rnd_mask, 5'b00011);
                    chk("p1r2_en0", p1_mul_en[0], 1);
                    chk("p1r2_en1", p1_mul_en[1], 0);
                    chk("p1r2_en2", p1_mul_en[2], 1);
                    chk("p1r2_en4", p1_mul_en[4], 1);
                end
                if (e.ph == 1 && e.rd == 1) begin
                    chk("p2r1_mask", rnd_mask, 5'b11110);
                    chk("p2r1_en0_3", p2_mul_en[3:0], 4'hf);
                    chk("p2r1_en8", p2_mul_en[8], 0);
                end
            end
        end
    endtask

    task automatic kick();
        exp_t e;
        for (int ph = 0; ph < 2; ph++)
            for (int rd = 0; rd < NPOINTS; rd++) begin
                e.ph = ph; e.rd = rd; sb.push_back(e);
            end
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (done) break;
        end
        chk("done_in_time", done, 1);
        chk("idle_round", round, 0);
        chk("idle_phase", phase, 0);
        chk("idle_mask", rnd_mask, 0);
        chk("idle_en", {p1_mul_en, p2_mul_en, add_en}, 0);
        cycle();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int hit;
        #12;
        chk("rst_outputs", {comp_go, coef_valid, tau_ready, phase, busy, done, round}, 0);
        chk("rst_vectors", {rnd_mask, p1_mul_en, p2_mul_en, add_en}, 0);
        rstb = 1'b1;
        cycle();
        chk("idle_busy", busy, 0);

        // All handshakes held high: full run of 2*NPOINTS rounds.
        comp_done = 1; coef_ready = 1; tau_valid = 1;
        go_cnt = 0; done_cnt = 0;
        kick();
        wait_done(100);
        chk("run1_go_pulses", go_cnt, 10);
        chk("run1_done_pulses", done_cnt, 1);

        // Stall coefficient emission for 7 cycles.
        coef_ready = 0; go_cnt = 0; done_cnt = 0;
        kick();
        for (int i = 0; i < 20; i++) begin
            if (coef_valid) break;
            cycle();
        end
        chk("emit_reached", coef_valid, 1);
        for (int k = 0; k < 7; k++) begin
            chk("stall_coef_valid", coef_valid, 1);
            chk("stall_no_tau_ready", tau_ready, 0);
            chk("stall_round", round, 0);
            if (k < 6) cycle();
        end
        coef_ready = 1;
        cycle();
        chk("rand_after_emit", tau_ready, 1);
        wait_done(100);
        chk("run2_go_pulses", go_cnt, 10);

        // start while busy and comp_done outside COMPUTE are ignored.
        comp_done = 0; tau_valid = 0; go_cnt = 0; done_cnt = 0;
        kick();
        start = 1;
        cycle();
        start = 0;
        chk("start_busy_ignored", {busy, coef_valid, round}, {1'b1, 1'b0, 3'd0});
        cycle();
        chk("compute_holds", coef_valid, 0);
        comp_done = 1;
        cycle();
        chk("emit_after_done", coef_valid, 1);
        comp_done = 0;
        cycle();
        chk("rand_entered", tau_ready, 1);
        comp_done = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("rand_ignores_comp_done", {tau_ready, coef_valid, round}, {1'b1, 1'b0, 3'd0});
        end
        comp_done = 1; coef_ready = 1; tau_valid = 1;
        wait_done(100);
        chk("run3_go_pulses", go_cnt, 10);

        // Reset in phase-2 round-3 RAND, then a fresh run.
        tau_valid = 0; go_cnt = 0; done_cnt = 0; hit = 0;
        kick();
        for (int i = 0; i < 200; i++) begin
            if (tau_ready) begin
                if (phase && round == 3) begin hit = 1; break; end
                tau_valid = 1; cycle(); tau_valid = 0;
            end else begin
                cycle();
            end
        end
        chk("reached_p2_r3", hit, 1);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_outputs", {comp_go, coef_valid, tau_ready, phase, busy, done, round}, 0);
        chk("async_rst_vectors", {rnd_mask, p1_mul_en, p2_mul_en, add_en}, 0);
        sb.delete();
        tau_valid = 1;
        cycle();
        cycle();
        rstb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("post_rst_idle", {busy, done}, 0);
        end
        chk("no_done_after_rst", done_cnt, 0);
        go_cnt = 0;
        kick();
        wait_done(100);
        chk("run4_go_pulses", go_cnt, 10);
        chk("run4_done_pulses", done_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
